// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of every signal between alu_cmd_sequencer and its environment.
//   Request side : in_valid, in_ready, in_a, in_b, in_cmd
//   ALU side     : alu_a, alu_b, alu_cmd, alu_oe (to ALU), alu_d (from ALU)
//   Result side  : res_valid, res_ready, res_data, res_cmd, res_err
//   Status       : fifo_count
// Modport slave is the sequencer itself; master is the surrounding logic
// (request producer, ALU and result consumer).
interface alu_cmd_sequencer_if #(
  parameter int unsigned CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [3:0]       in_cmd;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_cmd;
  logic             alu_oe;
  logic [15:0]      alu_d;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [3:0]       res_cmd;
  logic             res_err;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, alu_d, res_ready,
    output in_ready, alu_a, alu_b, alu_cmd, alu_oe,
    output res_valid, res_data, res_cmd, res_err, fifo_count
  );

  modport master (
    output in_valid, in_a, in_b, in_cmd, alu_d, res_ready,
    input  in_ready, alu_a, alu_b, alu_cmd, alu_oe,
    input  res_valid, res_data, res_cmd, res_err, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Wrapper stage around the 8-bit-operand / 16-bit-result combinational ALU.
// Requests (a, b, cmd) are buffered in a DEPTH-entry FIFO, issued one at a
// time to the ALU with a single-cycle output enable, and the ALU result is
// registered and offered downstream over valid/ready with a div-by-zero flag.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_cmd_sequencer_if.slave (request, ALU and result signals)
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic               clk,
  input logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam logic [3:0]  CmdDiv = 4'b0101;

  typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

  state_e           state_q;
  logic [19:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic [7:0]  alu_a_q, alu_b_q;
  logic [3:0]  alu_cmd_q;
  logic        alu_oe_q;
  logic        res_valid_q;
  logic [15:0] res_data_q;
  logic [3:0]  res_cmd_q;
  logic        res_err_q;

  logic        full, empty, push, pop, div_zero;
  logic [19:0] head;

  // Full is taken from the registered count, so a same-cycle pop never lets a
  // push in while full.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.in_valid && !full;
  assign head     = mem_q[rd_ptr_q];
  assign div_zero = (alu_cmd_q == CmdDiv) && (alu_b_q == 8'd0);

  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !empty;
      StHold:  pop = res_valid_q && bus.res_ready && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_cmd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      alu_oe_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            {alu_a_q, alu_b_q, alu_cmd_q} <= head;
            alu_oe_q <= 1'b1;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          // Divide by zero never samples the ALU bus, so res_data stays defined.
          alu_oe_q    <= 1'b0;
          res_valid_q <= 1'b1;
          res_data_q  <= div_zero ? 16'hFFFF : bus.alu_d;
          res_cmd_q   <= alu_cmd_q;
          res_err_q   <= div_zero;
          state_q     <= StHold;
        end
        StHold: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              {alu_a_q, alu_b_q, alu_cmd_q} <= head;
              alu_oe_q <= 1'b1;
              state_q  <= StDrive;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = !full;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.alu_oe     = alu_oe_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_cmd    = res_cmd_q;
  assign bus.res_err    = res_err_q;
  assign bus.fifo_count = count_q;

endmodule
